// File: rtl/cfg_reg_writer_if.sv
// Command/response channel between the control side (master) and cfg_reg_writer (slave).
interface cfg_reg_writer_if #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 16
) ();
   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_data;
   logic              rsp_valid;
   logic              rsp_err;
   logic [ADDR_W-1:0] rsp_addr;
   logic [DATA_W-1:0] rsp_rdata;

   modport master (
      output cmd_valid, cmd_addr, cmd_data,
      input  cmd_ready, rsp_valid, rsp_err, rsp_addr, rsp_rdata
   );

   modport slave (
      input  cmd_valid, cmd_addr, cmd_data,
      output cmd_ready, rsp_valid, rsp_err, rsp_addr, rsp_rdata
   );
endinterface

// File: rtl/cfg_reg_writer.sv
// Register-file write initiator with optional readback verify (CFG_WRITER_VERIFY_EN).
// One response per accepted command; saturating mismatch counter when verify is built in.
module cfg_reg_writer #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 16,
   parameter int RD_LAT = 1,
   parameter int ERR_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   cfg_reg_writer_if.slave   cmd,
   output logic              reg_write,
   output logic [ADDR_W-1:0] reg_address,
   output logic [DATA_W-1:0] reg_data_in,
   input  logic [DATA_W-1:0] reg_data_out,
   output logic [ERR_W-1:0]  err_count,
   output logic              busy
);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WRITE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   logic [1:0]        state_reg;
   logic [1:0]        state_next;
   logic [1:0]        after_write;
   logic [ADDR_W-1:0] addr_reg;
   logic [DATA_W-1:0] data_reg;
   logic              wait_done;
   logic              mismatch;

   // The held command doubles as the register-port drive, so the port keeps its last value.
   assign cmd.cmd_ready = (state_reg == ST_IDLE);
   assign busy          = (state_reg != ST_IDLE);
   assign reg_write     = (state_reg == ST_WRITE);
   assign reg_address   = addr_reg;
   assign reg_data_in   = data_reg;
   assign cmd.rsp_valid = (state_reg == ST_RESP);
   assign cmd.rsp_addr  = addr_reg;
   assign cmd.rsp_err   = (state_reg == ST_RESP) & mismatch;

`ifdef CFG_WRITER_VERIFY_EN
   localparam int               CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

   logic [CNT_W-1:0]  lat_cnt_reg;
   logic [DATA_W-1:0] rdata_reg;
   logic [ERR_W-1:0]  err_count_reg;
   logic [DATA_W-1:0] diff_bits;

   genvar gi;
   generate
      for (gi = 0; gi < DATA_W; gi++) begin : g_diff
         assign diff_bits[gi] = rdata_reg[gi] ^ data_reg[gi];
      end
   endgenerate

   assign mismatch    = |diff_bits;
   assign wait_done   = (lat_cnt_reg == CNT_LAST);
   assign after_write = ST_WAIT;
   assign cmd.rsp_rdata = rdata_reg;
   assign err_count   = err_count_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         lat_cnt_reg   <= '0;
         rdata_reg     <= '0;
         err_count_reg <= '0;
      end else begin
         if (state_reg == ST_WRITE)
            lat_cnt_reg <= '0;
         else if (state_reg == ST_WAIT && !wait_done)
            lat_cnt_reg <= lat_cnt_reg + CNT_W'(1);
         if (state_reg == ST_WAIT && wait_done)
            rdata_reg <= reg_data_out;
         // Counter sticks at all-ones rather than wrapping.
         if (state_reg == ST_RESP && mismatch && err_count_reg != '1)
            err_count_reg <= err_count_reg + ERR_W'(1);
      end
   end
`else
   logic [DATA_W+31:0] unused_inputs;

   assign unused_inputs = {reg_data_out, 32'(RD_LAT)};
   assign mismatch      = 1'b0;
   assign wait_done     = 1'b1;
   assign after_write   = ST_RESP;
   assign cmd.rsp_rdata = data_reg;
   assign err_count     = '0;
`endif

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (cmd.cmd_valid) state_next = ST_WRITE;
         ST_WRITE: state_next = after_write;
         ST_WAIT:  if (wait_done) state_next = ST_RESP;
         ST_RESP:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         addr_reg  <= '0;
         data_reg  <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == ST_IDLE && cmd.cmd_valid) begin
            addr_reg <= cmd.cmd_addr;
            data_reg <= cmd.cmd_data;
         end
      end
   end
endmodule

// File: tb/tb_cfg_reg_writer.sv
// Self-checking bench for cfg_reg_writer: timeline model of command/response behaviour,
// a register-file model with programmable read-as-zero addresses, directed and random traffic.
module tb_cfg_reg_writer;
   localparam int ADDR_W = 3;
   localparam int DATA_W = 16;
   localparam int RD_LAT = 1;
   localparam int ERR_W  = 8;
   localparam int ERR_MAX = (1 << ERR_W) - 1;

`ifdef CFG_WRITER_VERIFY_EN
   localparam bit VERIFY = 1'b1;
   localparam int L = RD_LAT;
   localparam logic [15:0] EXP_BAD_RDATA = 16'h0000;
   localparam int EXP_BAD_ERR = 1;
   localparam int EXP_ERR1 = 1;
   localparam int EXP_SAT = 255;
`else
   localparam bit VERIFY = 1'b0;
   localparam int L = 0;
   localparam logic [15:0] EXP_BAD_RDATA = 16'h2025;
   localparam int EXP_BAD_ERR = 0;
   localparam int EXP_ERR1 = 0;
   localparam int EXP_SAT = 0;
`endif
   localparam int EXP_RSP_WAIT = 1 + L;
   localparam int EXP_PERIOD = 3 + L;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic reg_write;
   logic [ADDR_W-1:0] reg_address;
   logic [DATA_W-1:0] reg_data_in;
   logic [DATA_W-1:0] reg_data_out = '0;
   logic [ERR_W-1:0] err_count;
   logic busy;

   cfg_reg_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cmd_if ();

   cfg_reg_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .ERR_W(ERR_W)) dut (
      .clk(clk), .reset(reset), .cmd(cmd_if),
      .reg_write(reg_write), .reg_address(reg_address), .reg_data_in(reg_data_in),
      .reg_data_out(reg_data_out), .err_count(err_count), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- register file model ----------------
   logic [DATA_W-1:0] mem [8];
   logic [DATA_W-1:0] pipe [RD_LAT];
   bit force_zero [8];
   logic lw;
   logic [ADDR_W-1:0] la;
   logic [DATA_W-1:0] ld;
   bit have_prev = 0;

   // Effects of edge j are applied at the following negedge using the port values seen before j.
   initial begin
      for (int i = 0; i < 8; i++) begin mem[i] = '0; force_zero[i] = 0; end
      for (int i = 0; i < RD_LAT; i++) pipe[i] = '0;
      forever begin
         @(negedge clk);
         if (have_prev) begin
            if (lw) mem[la] = ld;
            for (int i = RD_LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = force_zero[la] ? '0 : mem[la];
            reg_data_out = pipe[RD_LAT-1];
         end
         lw = reg_write; la = reg_address; ld = reg_data_in; have_prev = 1;
      end
   end

   // ---------------- behavioural timeline model ----------------
   int cyc = 0;
   bit model_ok = 0;
   bit pend = 0;
   int pend_due;
   logic [ADDR_W-1:0] pend_addr;
   logic [DATA_W-1:0] pend_data, pend_rdata;
   bit pend_err;
   int free_edge = 0;
   int wr_edge = -1;
   int err_exp = 0;

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         if (reset) begin
            model_ok = 1; pend = 0; err_exp = 0; free_edge = cyc + 1; wr_edge = -1;
         end else if (model_ok) begin
            if (pend && cyc == pend_due + 1) begin
               if (pend_err && err_exp < ERR_MAX) err_exp++;
               pend = 0;
            end
            if (cyc >= free_edge && cmd_if.cmd_valid) begin
               pend = 1;
               pend_due = cyc + 1 + L;
               pend_addr = cmd_if.cmd_addr;
               pend_data = cmd_if.cmd_data;
               pend_rdata = (VERIFY && force_zero[cmd_if.cmd_addr]) ? '0 : cmd_if.cmd_data;
               pend_err = (pend_rdata != pend_data);
               free_edge = cyc + 3 + L;
               wr_edge = cyc;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (model_ok) begin
            check("cmd_ready", 32'(cmd_if.cmd_ready), 32'(cyc + 1 >= free_edge));
            check("busy", 32'(busy), 32'(cyc + 1 < free_edge));
            check("reg_write", 32'(reg_write), 32'(wr_edge == cyc));
            if (wr_edge == cyc) begin
               check("reg_address", 32'(reg_address), 32'(pend_addr));
               check("reg_data_in", 32'(reg_data_in), 32'(pend_data));
            end
            check("rsp_valid", 32'(cmd_if.rsp_valid), 32'(pend && pend_due == cyc));
            if (pend && pend_due == cyc) begin
               check("rsp_addr", 32'(cmd_if.rsp_addr), 32'(pend_addr));
               check("rsp_rdata", 32'(cmd_if.rsp_rdata), 32'(pend_rdata));
               check("rsp_err", 32'(cmd_if.rsp_err), 32'(pend_err));
            end
            check("err_count", 32'(err_count), 32'(err_exp));
         end
      end
   end

   // ---------------- driver ----------------
   int last_accept = 0;

   // Called at a negedge; returns at the negedge right after the accepting edge.
   task automatic send(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      int n = 0;
      cmd_if.cmd_addr = a; cmd_if.cmd_data = d; cmd_if.cmd_valid = 1'b1;
      while (!cmd_if.cmd_ready && n < 40) begin @(negedge clk); n++; end
      if (!cmd_if.cmd_ready) begin
         checks++; failures++;
         $display("FAIL accept_timeout actual=busy required=ready addr=%0h", a);
      end
      last_accept = cyc + 1;
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int n, output logic [DATA_W-1:0] rd, output logic er);
      n = 0;
      while (!cmd_if.rsp_valid && n < 20) begin @(negedge clk); n++; end
      rd = cmd_if.rsp_rdata; er = cmd_if.rsp_err;
      $display("rsp addr=%0h rdata=%04h err=%0b after %0d cycles", cmd_if.rsp_addr, rd, er, n);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, a1;
      logic [DATA_W-1:0] rd;
      logic er;
      cmd_if.cmd_valid = 1'b0; cmd_if.cmd_addr = '0; cmd_if.cmd_data = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // reset values
      check("rst_cmd_ready", 32'(cmd_if.cmd_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_reg_write", 32'(reg_write), 32'd0);
      check("rst_reg_address", 32'(reg_address), 32'd0);
      check("rst_reg_data_in", 32'(reg_data_in), 32'd0);
      check("rst_rsp_valid", 32'(cmd_if.rsp_valid), 32'd0);
      check("rst_rsp_err", 32'(cmd_if.rsp_err), 32'd0);
      check("rst_rsp_addr", 32'(cmd_if.rsp_addr), 32'd0);
      check("rst_rsp_rdata", 32'(cmd_if.rsp_rdata), 32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);

      // echoing write
      send(3'd3, 16'h8000);
      wait_rsp(n, rd, er);
      check("echo_latency", 32'(n), 32'(EXP_RSP_WAIT));
      check("echo_rdata", 32'(rd), 32'h8000);
      check("echo_err", 32'(er), 32'd0);

      // forced read-as-zero
      force_zero[3] = 1;
      send(3'd3, 16'h2025);
      wait_rsp(n, rd, er);
      check("bad_rdata", 32'(rd), 32'(EXP_BAD_RDATA));
      check("bad_err", 32'(er), 32'(EXP_BAD_ERR));
      @(negedge clk);
      check("bad_err_count", 32'(err_count), 32'(EXP_ERR1));

      // back-to-back with valid held high
      send(3'd1, 16'h1111);
      a1 = last_accept;
      send(3'd2, 16'h2222);
      check("b2b_period", 32'(last_accept - a1), 32'(EXP_PERIOD));
      wait_rsp(n, rd, er);
      check("b2b_rdata2", 32'(rd), 32'h2222);

      // reset in the middle of a command
      repeat (4) @(negedge clk);
      send(3'd4, 16'h4444);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midrst_rsp_valid", 32'(cmd_if.rsp_valid), 32'd0);
      check("midrst_cmd_ready", 32'(cmd_if.cmd_ready), 32'd1);
      check("midrst_err_count", 32'(err_count), 32'd0);
      send(3'd5, 16'h5555);
      wait_rsp(n, rd, er);
      check("postrst_rdata", 32'(rd), 32'h5555);
      check("postrst_err", 32'(er), 32'd0);

      // saturation
      force_zero[7] = 1;
      for (int i = 0; i < 260; i++) send(3'd7, 16'h1000 + 16'(i));
      repeat (8) @(negedge clk);
      check("sat_err_count", 32'(err_count), 32'(EXP_SAT));
      check("sat_model", 32'(err_exp), 32'(EXP_SAT));

      // random traffic, occasional resets between commands
      for (int i = 0; i < 8; i++) force_zero[i] = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 300; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         send(3'($urandom_range(0, 7)), 16'($urandom));
         if ($urandom_range(0, 49) == 0) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
         end
      end
      repeat (10) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
